// File: rtl/vga_scanout.sv
// 640x480@60 VGA scan-out: 2x-upscaled 256x240 8bpp image centred in the frame, fetched via VGA_ADDR/VGA_DATA.
// Optional feature: define VGA_TESTPAT_EN to add a TP_SEL input selecting 8 vertical colour bars.
module vga_scanout #(
    parameter int PIX_DIV = 2,
    parameter int RD_LAT  = 1,
    parameter int H_ACT   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_ACT   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int IMG_X0  = 64
) (
    input  logic        CLK,
    input  logic        RST,
`ifdef VGA_TESTPAT_EN
    input  logic        TP_SEL,
`endif
    output logic [15:0] VGA_ADDR,
    input  logic [7:0]  VGA_DATA,
    input  logic        VGA_EN,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic [3:0]  R,
    output logic [3:0]  G,
    output logic [3:0]  B,
    output logic        FRAME_START
);

    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int CW    = $clog2((H_TOT > V_TOT) ? H_TOT : V_TOT);
    localparam int DW    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOT - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOT - 1);
    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACT);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACT);
    localparam logic [CW-1:0] WIN_LO   = CW'(IMG_X0);
    localparam logic [CW-1:0] WIN_HI   = CW'(IMG_X0 + 512);
    localparam logic [CW-1:0] HS_LO    = CW'(H_ACT + H_FP);
    localparam logic [CW-1:0] HS_HI    = CW'(H_ACT + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_LO    = CW'(V_ACT + V_FP);
    localparam logic [CW-1:0] VS_HI    = CW'(V_ACT + V_FP + V_SYNC);

    typedef struct packed {
        logic       win;
        logic       hs_n;
        logic       vs_n;
        logic       fs;
`ifdef VGA_TESTPAT_EN
        logic [2:0] bar;
`endif
    } tap_t;

`ifdef VGA_TESTPAT_EN
    localparam tap_t TAP_IDLE = '{win: 1'b0, hs_n: 1'b1, vs_n: 1'b1, fs: 1'b0, bar: 3'd0};
`else
    localparam tap_t TAP_IDLE = '{win: 1'b0, hs_n: 1'b1, vs_n: 1'b1, fs: 1'b0};
`endif

    logic [DW-1:0] div;
    logic [CW-1:0] hcnt;
    logic [CW-1:0] vcnt;
    logic          tick;
    logic          act;
    logic [7:0]    x_img;
    logic [7:0]    y_img;
    tap_t          s0;
    tap_t          dl [0:RD_LAT];
    tap_t          tap;
    logic [3:0]    r_n, g_n, b_n;

    assign tick = (div == DIV_LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            div  <= '0;
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
                if (hcnt == H_LAST) begin
                    hcnt <= '0;
                    vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        act     = (hcnt < H_ACT_C) && (vcnt < V_ACT_C);
        x_img   = 8'((hcnt - WIN_LO) >> 1);
        y_img   = 8'(vcnt >> 1);
        s0.win  = act && (hcnt >= WIN_LO) && (hcnt < WIN_HI);
        s0.hs_n = !((hcnt >= HS_LO) && (hcnt < HS_HI));
        s0.vs_n = !((vcnt >= VS_LO) && (vcnt < VS_HI));
        s0.fs   = (hcnt == '0) && (vcnt == '0) && (div == '0);
`ifdef VGA_TESTPAT_EN
        s0.bar  = 3'((hcnt - WIN_LO) >> 6);
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            VGA_ADDR <= '0;
        end else begin
            VGA_ADDR <= s0.win ? {y_img, x_img} : 16'h0000;
        end
    end

    // NOTE: the delay line is a handful of flops, not a RAM, so it is reset to keep stale pixels off the pins.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i <= RD_LAT; i++) dl[i] <= TAP_IDLE;
        end else begin
            dl[0] <= s0;
            for (int i = 1; i <= RD_LAT; i++) dl[i] <= dl[i-1];
        end
    end

    assign tap = dl[RD_LAT];

`ifdef VGA_TESTPAT_EN
    logic tp_sel_q;

    always_ff @(posedge CLK) begin
        if (!RST) tp_sel_q <= 1'b0;
        else      tp_sel_q <= TP_SEL;
    end
`endif

    // NOTE: defaults first so no path through this block can infer a latch.
    always_comb begin
        r_n = '0;
        g_n = '0;
        b_n = '0;
`ifdef VGA_TESTPAT_EN
        if (tap.win && tp_sel_q) begin
            r_n = {4{tap.bar[2]}};
            g_n = {4{tap.bar[1]}};
            b_n = {4{tap.bar[0]}};
        end else
`endif
        if (tap.win && VGA_EN) begin
            r_n = {VGA_DATA[7:5], VGA_DATA[7]};
            g_n = {VGA_DATA[4:2], VGA_DATA[4]};
            b_n = {VGA_DATA[1:0], VGA_DATA[1:0]};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            HSYNC       <= 1'b1;
            VSYNC       <= 1'b1;
            FRAME_START <= 1'b0;
            R           <= '0;
            G           <= '0;
            B           <= '0;
        end else begin
            HSYNC       <= tap.hs_n;
            VSYNC       <= tap.vs_n;
            FRAME_START <= tap.fs;
            R           <= r_n;
            G           <= g_n;
            B           <= b_n;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout with a 12-line vertical timing so whole frames fit in a short run.
// Sample point k = number of rising edges since reset release; pins show counter state k-3, VGA_ADDR state k-1.
module tb_vga_scanout;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] vga_addr;
    logic [7:0]  vga_data;
    logic        vga_en;
    logic        hsync, vsync;
    logic [3:0]  r, g, b;
    logic        frame_start;
`ifdef VGA_TESTPAT_EN
    logic        tp_sel;
`endif

    int checks = 0;
    int errors = 0;
    int k      = 0;

    always #5 clk = ~clk;

    vga_scanout #(
        .PIX_DIV(2), .RD_LAT(1),
        .H_ACT(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACT(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .IMG_X0(64)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
`ifdef VGA_TESTPAT_EN
        .TP_SEL     (tp_sel),
`endif
        .VGA_ADDR   (vga_addr),
        .VGA_DATA   (vga_data),
        .VGA_EN     (vga_en),
        .HSYNC      (hsync),
        .VSYNC      (vsync),
        .R          (r),
        .G          (g),
        .B          (b),
        .FRAME_START(frame_start)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    task automatic goto(input int target);
        repeat (target - k) @(negedge clk);
        k = target;
    endtask

    initial begin
        rst      = 1'b0;
        vga_data = 8'hE3;
        vga_en   = 1'b1;
`ifdef VGA_TESTPAT_EN
        tp_sel   = 1'b0;
`endif
        repeat (50) @(negedge clk);
        check("rst_hsync", 16'(hsync), 16'h1);
        check("rst_vsync", 16'(vsync), 16'h1);
        check("rst_rgb",   16'({r, g, b}), 16'h000);
        check("rst_addr",  vga_addr, 16'h0000);
        check("rst_fs",    16'(frame_start), 16'h0);

        rst = 1'b1;
        k   = 0;
        goto(2);     check("fs_early",      16'(frame_start), 16'h0);
        goto(3);     check("fs_first",      16'(frame_start), 16'h1);
        goto(4);     check("fs_one_clk",    16'(frame_start), 16'h0);
        goto(127);   check("addr_border_l", vga_addr, 16'h0000);
        goto(130);   check("rgb_border_l",  16'({r, g, b}), 16'h000);
        goto(131);   check("rgb_win_first", 16'({r, g, b}), 16'hF0F);
        goto(133);   check("addr_x1",       vga_addr, 16'h0001);

        goto(202);   check("rgb_before_gap", 16'({r, g, b}), 16'hF0F);
        vga_en = 1'b0;
        goto(203);   check("rgb_gap_0",      16'({r, g, b}), 16'h000);
        goto(204);   check("rgb_gap_1",      16'({r, g, b}), 16'h000);
        vga_en = 1'b1;
        goto(205);   check("rgb_after_gap",  16'({r, g, b}), 16'hF0F);

        goto(1151);  check("addr_x255",     vga_addr, 16'h00FF);
        goto(1153);  check("addr_border_r", vga_addr, 16'h0000);
                     check("rgb_win_last",  16'({r, g, b}), 16'hF0F);
        goto(1155);  check("rgb_border_r",  16'({r, g, b}), 16'h000);

        goto(1314);  check("hs_pre",     16'(hsync), 16'h1);
        goto(1315);  check("hs_fall",    16'(hsync), 16'h0);
        goto(1506);  check("hs_last",    16'(hsync), 16'h0);
        goto(1507);  check("hs_rise",    16'(hsync), 16'h1);
        goto(2914);  check("hs2_pre",    16'(hsync), 16'h1);
        goto(2915);  check("hs2_fall",   16'(hsync), 16'h0);

        goto(3329);  check("addr_l2_first", vga_addr, 16'h0100);
        goto(3333);  check("addr_l2_x1",    vga_addr, 16'h0101);
        goto(4351);  check("addr_l2_last",  vga_addr, 16'h01FF);
        goto(5951);  check("addr_l3_last",  vga_addr, 16'h01FF);
        goto(12351); check("addr_lastline", vga_addr, 16'h03FF);
        goto(13001); check("addr_vblank",   vga_addr, 16'h0000);
        goto(13003); check("rgb_vblank",    16'({r, g, b}), 16'h000);

        goto(14402); check("vs_pre",   16'(vsync), 16'h1);
        goto(14403); check("vs_fall",  16'(vsync), 16'h0);
        goto(17602); check("vs_last",  16'(vsync), 16'h0);
        goto(17603); check("vs_rise",  16'(vsync), 16'h1);

        goto(19202); check("fs2_early", 16'(frame_start), 16'h0);
        goto(19203); check("fs2",       16'(frame_start), 16'h1);
        goto(19204); check("fs2_end",   16'(frame_start), 16'h0);

        // One-clock reset at (hcnt 300, vcnt 5) of the second frame.
        goto(27800); check("rgb_pre_pulse", 16'({r, g, b}), 16'hF0F);
        rst = 1'b0;
        goto(27801); check("pulse_addr",  vga_addr, 16'h0000);
                     check("pulse_hsync", 16'(hsync), 16'h1);
                     check("pulse_rgb",   16'({r, g, b}), 16'h000);
        rst = 1'b1;
        k   = 0;
        goto(1);     check("pulse_pipe_clear", 16'({r, g, b}), 16'h000);
        goto(2);     check("pulse_fs_early",   16'(frame_start), 16'h0);
        goto(3);     check("pulse_fs",         16'(frame_start), 16'h1);
        goto(133);   check("pulse_addr_x1",    vga_addr, 16'h0001);
        goto(1315);  check("pulse_hs_fall",    16'(hsync), 16'h0);

`ifdef VGA_TESTPAT_EN
        tp_sel = 1'b1;
        goto(1731);  check("tp_bar0", 16'({r, g, b}), 16'h000);
        goto(1987);  check("tp_bar2", 16'({r, g, b}), 16'h0F0);
        goto(2371);  check("tp_bar5", 16'({r, g, b}), 16'hF0F);
        goto(2627);  check("tp_bar7", 16'({r, g, b}), 16'hFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Display-side consumer of the framebuffer read port served by the control block.
- Generates 640x480@60 VGA timing from the 50 MHz system clock, with a 25 MHz pixel slot of 2 clocks.
- Issues VGA_ADDR for a 256x240 8bpp image and samples returned VGA_DATA/VGA_EN.
- Drives 4-4-4 RGB plus syncs; the image is 2x upscaled and centred (512x480 window, 64-pixel side borders).

Parameters:
PIX_DIV, 2, clocks per pixel slot (>=1)
RD_LAT, 1, clocks from VGA_ADDR change to matching VGA_DATA/VGA_EN (>=1)
H_ACT/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels (total 800)
V_ACT/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines (total 525)
IMG_X0, 64, first hcnt of the image window

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  synchronous reset, active-low
VGA_ADDR  out  16  framebuffer read address, {y_img[7:0], x_img[7:0]}
VGA_DATA  in  8  pixel returned by the control block, RGB 3:3:2
VGA_EN  in  1  control block's data-valid for VGA_DATA; low forces black
HSYNC  out  1  horizontal sync, active-low
VSYNC  out  1  vertical sync, active-low
R, G, B  out  4 each  pixel colour
FRAME_START  out  1  one-clock pulse aligned with the output of pixel (0,0)

Behaviour:
- Reset (RST=0 at a clock edge):
  - div, hcnt, vcnt = 0; VGA_ADDR = 0; HSYNC = VSYNC = 1; R = G = B = 0; FRAME_START = 0.
  - All delay-pipeline stages cleared to these inactive values.
  - Asserting reset mid-frame aborts the frame. The first clock after release is slot (0,0), div = 0.
- Counters:
  - div counts 0..PIX_DIV-1; tick = (div == PIX_DIV-1).
  - On tick, hcnt increments and wraps 799 -> 0.
  - On the tick where hcnt wraps, vcnt increments and wraps 524 -> 0. Both wraps on the same tick return to (0,0).
- Decode from the current counters (combinational, stage 0):
  - act = hcnt < 640 && vcnt < 480.
  - win = act && hcnt in [64,576).
  - hs_n = !(hcnt in [656,752)); vs_n = !(vcnt in [490,492)).
  - fs = (hcnt == 0 && vcnt == 0 && div == 0).
- Address:
  - x_img = (hcnt-64)>>1 and y_img = vcnt>>1 (each 8 bits).
  - VGA_ADDR is registered: next = win ? {y_img, x_img} : 0.
  - The address changes exactly one clock after the counters. Maximum address is 239*256+255 = 0xEFFF; 0xF000..0xFFFF are never issued.
- Output alignment:
  - win, hs_n, vs_n and fs pass through a delay line of RD_LAT+1 registers.
  - R, G, B and the sync outputs are registered in the same clock from the delayed window flag and the live VGA_DATA/VGA_EN.
  - Counter-to-pin latency is RD_LAT+2 clocks, identical for syncs, colour and FRAME_START.
- Colour:
  - If delayed win && VGA_EN: R = {d[7:5], d[7]}, G = {d[4:2], d[4]}, B = {d[1:0], d[1:0]}.
  - Otherwise R = G = B = 0 (borders, blanking, invalid data).
- Data sampling:
  - VGA_DATA is sampled every clock. The control block must hold the data for the full pixel slot.
  - A VGA_EN drop inside a slot blacks out only the clocks where it is low.

Optional Feature:
- Macro: VGA_TESTPAT_EN.
- Defined:
  - Adds input TP_SEL (1 bit, registered once).
  - While TP_SEL = 1, inside the window R/G/B come from 8 vertical colour bars of 64 pixels each; bar index = (hcnt-64)>>6, colour = {idx[2],idx[1],idx[0]} each replicated to 4 bits.
  - VGA_DATA and VGA_EN are ignored; VGA_ADDR keeps counting normally.
- Undefined: no TP_SEL port; colour is always from VGA_DATA.

Test Plan:
- Reset held 50 clocks, then released.
  - During reset: HSYNC = VSYNC = 1, RGB = 0, VGA_ADDR = 0.
  - First FRAME_START exactly RD_LAT+2 clocks after release.
- Run one full frame: 800*525*2 = 840000 clocks between FRAME_START pulses.
  - HSYNC low for 192 clocks every 1600.
  - VSYNC low for exactly 2 lines (3200 clocks).
- Address sequence:
  - Line 0: VGA_ADDR 0 for hcnt < 64, then 0x0000, 0x0000 (x2 slots), ..., 0x00FF, then 0.
  - Lines 2/3 issue 0x0100..0x01FF.
  - Line 479 issues 0xEF00..0xEFFF.
- Model returns VGA_DATA = 0xE3 with VGA_EN = 1 after RD_LAT.
  - Window pixels: R = 0xF, G = 0x0, B = 0xF.
  - Border pixels (hcnt 0..63, 576..639) and blanking: RGB = 0.
- VGA_EN held 0 for one slot mid-line -> exactly that pixel (2 clocks) is black; neighbours unchanged.
- Reset pulsed for 1 clock at (hcnt = 300, vcnt = 200) -> counters restart at (0,0) and the next FRAME_START comes RD_LAT+2 clocks after release.
- With VGA_TESTPAT_EN and TP_SEL = 1:
  - At hcnt = 64+64*k, RGB = bar k colour; bar 5 gives R = 0xF, G = 0x0, B = 0xF.
